// File: rtl/uart_pkg.sv
// Shared defaults and drain-state encoding for the UART transmit FIFO.
package uart_pkg;
    localparam int DATA_W_DEF = 8;
    localparam int DEPTH_DEF  = 8;

    typedef enum logic {
        IDLE      = 1'b0,
        WAIT_DONE = 1'b1
    } drain_state_t;
endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO storage with read/write pointers and one shared occupancy count.
module sync_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [DATA_W-1:0]        push_data,
    input  logic                     pop,
    output logic [DATA_W-1:0]        pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_push;
    logic              do_pop;

    // full/empty come from the registered count, so a pop never frees a slot for a same-cycle push
    assign full     = (count == FULL_CNT);
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding a UART transmitter: pops one byte per frame, holding it until tx_done.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [DATA_W-1:0]        wr_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     tx_start,
    output logic [DATA_W-1:0]        tx_data,
    input  logic                     tx_done,
    output logic                     busy
);
    drain_state_t      state;
    logic              pop;
    logic [DATA_W-1:0] pop_data;

    assign pop  = (state == IDLE) && !empty;
    assign busy = (state == WAIT_DONE);

    sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (wr_en),
        .push_data (wr_data),
        .pop       (pop),
        .pop_data  (pop_data),
        .full      (full),
        .empty     (empty),
        .count     (count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            tx_start <= 1'b0;
            tx_data  <= '0;
            overflow <= 1'b0;
        end else begin
            tx_start <= 1'b0;
            if (wr_en && full) begin
                overflow <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (pop) begin
                        tx_data  <= pop_data;
                        tx_start <= 1'b1;
                        state    <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (tx_done) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomised and directed bench for uart_tx_fifo against a queue-based transaction model.
module tb_uart_tx_fifo;
    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = '0;
    logic       tx_done = 1'b0;
    logic       full, empty, overflow, tx_start, busy;
    logic [3:0] count;
    logic [7:0] tx_data;

    uart_tx_fifo #(.DATA_W(8), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .overflow (overflow),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .tx_done  (tx_done),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // model: queued bytes, one in-flight slot, sticky overflow
    logic [7:0] q[$];
    logic [7:0] acc_log[$];
    logic [7:0] dut_log[$];
    logic       m_busy = 1'b0;
    logic       m_start = 1'b0;
    logic [7:0] m_data = '0;
    logic       m_ovf = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input logic r, input logic w, input logic [7:0] d, input logic done);
        logic was_full;
        if (r) begin
            q.delete();
            acc_log.delete();
            m_busy = 1'b0; m_start = 1'b0; m_data = '0; m_ovf = 1'b0;
            return;
        end
        was_full = (q.size() == DEPTH);
        m_start  = 1'b0;
        if (m_busy) begin
            if (done) m_busy = 1'b0;
        end else if (q.size() > 0) begin
            m_data  = q.pop_front();
            m_start = 1'b1;
            m_busy  = 1'b1;
        end
        if (w) begin
            if (was_full) m_ovf = 1'b1;
            else begin
                q.push_back(d);
                acc_log.push_back(d);
            end
        end
    endtask

    task automatic check_all();
        chk("count", 32'(count), 32'(q.size()));
        chk("empty", 32'(empty), 32'(q.size() == 0));
        chk("full", 32'(full), 32'(q.size() == DEPTH));
        chk("busy", 32'(busy), 32'(m_busy));
        chk("tx_start", 32'(tx_start), 32'(m_start));
        chk("tx_data", 32'(tx_data), 32'(m_data));
        chk("overflow", 32'(overflow), 32'(m_ovf));
    endtask

    task automatic tick(input logic r, input logic w, input logic [7:0] d, input logic done);
        rst = r; wr_en = w; wr_data = d; tx_done = done;
        model_step(r, w, d, done);
        @(posedge clk);
        #1;
        check_all();
        if (r) dut_log.delete();
        else if (tx_start) dut_log.push_back(tx_data);
        rst = 1'b0; wr_en = 1'b0; tx_done = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && (q.size() > 0 || m_busy); i++) begin
            tick(1'b0, 1'b0, 8'h00, m_busy);
        end
        chk("drain_busy", 32'(busy), 32'd0);
        chk("drain_empty", 32'(empty), 32'd1);
    endtask

    initial begin
        int bc;
        int wait_cnt;
        logic dn;

        // single byte, 20-cycle frame
        tick(1'b1, 1'b0, 8'h00, 1'b0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        tick(1'b0, 1'b1, 8'h41, 1'b0);
        chk("s34_nostart", 32'(tx_start), 32'd0);
        tick(1'b0, 1'b0, 8'h00, 1'b0);
        chk("s34_start", 32'(tx_start), 32'd1);
        chk("s34_data", 32'(tx_data), 32'h41);
        bc = int'(busy);
        repeat (19) begin
            tick(1'b0, 1'b0, 8'h00, 1'b0);
            bc += int'(busy);
        end
        tick(1'b0, 1'b0, 8'h00, 1'b1);
        bc += int'(busy);
        chk("s34_busy_cycles", 32'(bc), 32'd20);
        chk("s34_empty", 32'(empty), 32'd1);

        // burst to full, overflow, transmit order
        tick(1'b1, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 8; i++) tick(1'b0, 1'b1, 8'(8'h10 + i), 1'b0);
        chk("s35_count7", 32'(count), 32'd7);
        tick(1'b0, 1'b1, 8'h18, 1'b0);
        chk("s35_full", 32'(full), 32'd1);
        tick(1'b0, 1'b1, 8'h99, 1'b0);
        chk("s35_ovf", 32'(overflow), 32'd1);
        chk("s35_count8", 32'(count), 32'd8);
        drain();
        chk("s35_ntx", 32'(dut_log.size()), 32'd9);
        for (int i = 0; i < 9 && i < dut_log.size(); i++)
            chk("s35_order", 32'(dut_log[i]), 32'(8'h10 + i));

        // reset during WAIT_DONE with 3 queued
        tick(1'b1, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b1, 8'(8'hA0 + i), 1'b0);
        chk("s37_pre_count", 32'(count), 32'd3);
        chk("s37_pre_busy", 32'(busy), 32'd1);
        tick(1'b1, 1'b1, 8'hEE, 1'b1);
        chk("s37_count", 32'(count), 32'd0);
        chk("s37_busy", 32'(busy), 32'd0);
        chk("s37_data", 32'(tx_data), 32'h00);
        chk("s37_ovf", 32'(overflow), 32'd0);

        // tx_done while idle is ignored
        tick(1'b0, 1'b0, 8'h00, 1'b1);
        chk("s38_nostart", 32'(tx_start), 32'd0);
        tick(1'b0, 1'b1, 8'h55, 1'b0);
        bc = 0;
        repeat (6) begin
            tick(1'b0, 1'b0, 8'h00, 1'b0);
            if (tx_start) begin
                bc++;
                chk("s38_data", 32'(tx_data), 32'h55);
            end
        end
        chk("s38_starts", 32'(bc), 32'd1);

        // randomised traffic with wrap and overflow, loopback scoreboard
        tick(1'b1, 1'b0, 8'h00, 1'b0);
        wait_cnt = 0;
        for (int i = 0; i < 3000; i++) begin
            dn = m_busy && (wait_cnt == 0);
            tick(1'b0, ($urandom_range(0, 99) < 55), 8'($urandom), dn);
            if (m_start) wait_cnt = $urandom_range(0, 6);
            else if (m_busy && wait_cnt > 0) wait_cnt--;
        end
        drain();
        chk("rnd_ge20", 32'(dut_log.size() >= 20), 32'd1);
        chk("rnd_ntx", 32'(dut_log.size()), 32'(acc_log.size()));
        for (int i = 0; i < acc_log.size() && i < dut_log.size(); i++)
            chk("rnd_rx", 32'(dut_log[i]), 32'(acc_log[i]));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
